// File: rtl/test_vec_checker_if.sv
// DUT-facing vector bus of the checker.
//   dut_a, dut_b : operands, driven by the checker (master).
//   dut_y        : DUT result, driven by the device under test (slave).
// Lane k occupies bits [k*WIDTH +: WIDTH] of each bus.
interface test_vec_checker_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 1
);
  logic [LANES*WIDTH-1:0] dut_a;
  logic [LANES*WIDTH-1:0] dut_b;
  logic [LANES*WIDTH-1:0] dut_y;

  modport master (output dut_a, output dut_b, input dut_y);
  modport slave  (input dut_a, input dut_b, output dut_y);
endinterface

// File: rtl/test_vec_checker.sv
// Self-checking vector source/sink for one DUT in the test harness.
// Issues a deterministic operand stream, carries the golden result down a
// LATENCY-deep pipe, and compares it with dut_y when it surfaces.
//   clock   : rising-edge clock
//   reset   : synchronous, active-high; clears all state and outputs
//   fail    : sticky, first mismatch seen
//   finish  : sticky, run over (pass or fail)
//   err_idx : index of first failing vector, 0 otherwise
//   dut     : operand/result bus (master side)

// Per-lane operand and golden generator, purely combinational.
module test_vec_checker_lane #(
  parameter int WIDTH = 8,
  parameter int OP    = 0,
  parameter int LANE  = 0
) (
  input  logic [15:0]      idx,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] golden
);
  // Everything is mod 2^WIDTH, so truncating idx up front is harmless.
  always_comb begin
    a      = WIDTH'(3) * WIDTH'(idx) + WIDTH'(LANE);
    b      = WIDTH'(7) * WIDTH'(idx) + WIDTH'(2 * LANE + 1);
    golden = (OP == 0) ? a + b : a - b;
  end
endmodule

module test_vec_checker #(
  parameter int WIDTH       = 8,
  parameter int LANES       = 1,
  parameter int OP          = 0,
  parameter int LATENCY     = 2,
  parameter int NUM_VECTORS = 16
) (
  input  logic               clock,
  input  logic               reset,
  output logic               fail,
  output logic               finish,
  output logic [15:0]        err_idx,
  test_vec_checker_if.master dut
);
  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_DRAIN, S_DONE, S_FAIL} state_t;

  state_t state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic        issue, cmp_en, mismatch, last_cmp;

  logic [LANES-1:0][WIDTH-1:0] lane_a, lane_b, lane_g;
  logic [LANES-1:0][WIDTH-1:0] a_q, b_q;

  // Stage s holds the entry issued s-1 edges ago; stage LATENCY is the tap
  // compared against dut_y.
  logic [LATENCY:1]                         vld_pipe;
  logic [LATENCY:1][LANES-1:0][WIDTH-1:0]   gold_pipe;
  logic [LATENCY:1][15:0]                   idx_pipe;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    test_vec_checker_lane #(.WIDTH(WIDTH), .OP(OP), .LANE(k)) u_lane (
      .idx    (idx_q),
      .a      (lane_a[k]),
      .b      (lane_b[k]),
      .golden (lane_g[k])
    );
  end

  assign dut.dut_a = a_q;
  assign dut.dut_b = b_q;

  // Next state. Vector 0 goes out on the IDLE->DRIVE edge, so IDLE issues too.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    issue    = 1'b0;
    cmp_en   = vld_pipe[LATENCY] && (state_q == S_DRIVE || state_q == S_DRAIN);
    mismatch = cmp_en && (dut.dut_y != gold_pipe[LATENCY]);
    last_cmp = cmp_en && (idx_pipe[LATENCY] == LAST_IDX);
    case (state_q)
      S_IDLE: begin
        issue   = 1'b1;
        idx_d   = 16'd1;
        state_d = (NUM_VECTORS == 1) ? S_DRAIN : S_DRIVE;
      end
      S_DRIVE: begin
        issue = 1'b1;
        idx_d = idx_q + 16'd1;
        if (idx_q == LAST_IDX) state_d = S_DRAIN;
      end
      S_DRAIN: if (last_cmp) state_d = S_DONE;
      default: ;
    endcase
    // A failing last compare must land in FAIL, not DONE.
    if (mismatch) state_d = S_FAIL;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      vld_pipe  <= '0;
      gold_pipe <= '0;
      idx_pipe  <= '0;
      fail      <= 1'b0;
      finish    <= 1'b0;
      err_idx   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= issue ? lane_a : '0;
      b_q     <= issue ? lane_b : '0;

      vld_pipe[1]  <= issue;
      gold_pipe[1] <= lane_g;
      idx_pipe[1]  <= idx_q;
      for (int s = 2; s <= LATENCY; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        gold_pipe[s] <= gold_pipe[s-1];
        idx_pipe[s]  <= idx_pipe[s-1];
      end

      // cmp_en is only true while running, so these hold once terminal.
      if (mismatch) begin
        fail    <= 1'b1;
        finish  <= 1'b1;
        err_idx <= idx_pipe[LATENCY];
      end else if (state_q == S_DRAIN && last_cmp) begin
        finish <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_test_vec_checker.sv
// Four checker instances run side by side against bench-built DUTs:
//   u0: scalar add, 2-stage DUT (pass run, fault run, mid-run reset run)
//   u1: scalar add, 40 vectors (lane wrap)
//   u2: 4-lane sub
//   u3: LATENCY=2 checker against a 1-stage (combinational) DUT
module tb_test_vec_checker;
  localparam int NI = 4;
  localparam int NV  [NI] = '{16, 40, 16, 16};
  localparam int LAT [NI] = '{2, 2, 2, 2};
  localparam int LN  [NI] = '{1, 1, 4, 1};
  localparam int OPS [NI] = '{0, 0, 1, 0};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [NI-1:0] rst;
  logic          inj, inj_m;
  logic          run_chk;
  int            ph;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cnt [NI];

  logic        fail_w   [NI];
  logic        finish_w [NI];
  logic [15:0] err_w    [NI];
  logic [31:0] a_w [NI], b_w [NI], y_w [NI];

  test_vec_checker_if #(.WIDTH(8), .LANES(1)) if0 ();
  test_vec_checker_if #(.WIDTH(8), .LANES(1)) if1 ();
  test_vec_checker_if #(.WIDTH(8), .LANES(4)) if2 ();
  test_vec_checker_if #(.WIDTH(8), .LANES(1)) if3 ();

  test_vec_checker #(.WIDTH(8), .LANES(1), .OP(0), .LATENCY(2), .NUM_VECTORS(16)) u0 (
    .clock(clock), .reset(rst[0]), .fail(fail_w[0]), .finish(finish_w[0]),
    .err_idx(err_w[0]), .dut(if0));
  test_vec_checker #(.WIDTH(8), .LANES(1), .OP(0), .LATENCY(2), .NUM_VECTORS(40)) u1 (
    .clock(clock), .reset(rst[1]), .fail(fail_w[1]), .finish(finish_w[1]),
    .err_idx(err_w[1]), .dut(if1));
  test_vec_checker #(.WIDTH(8), .LANES(4), .OP(1), .LATENCY(2), .NUM_VECTORS(16)) u2 (
    .clock(clock), .reset(rst[2]), .fail(fail_w[2]), .finish(finish_w[2]),
    .err_idx(err_w[2]), .dut(if2));
  test_vec_checker #(.WIDTH(8), .LANES(1), .OP(0), .LATENCY(2), .NUM_VECTORS(16)) u3 (
    .clock(clock), .reset(rst[3]), .fail(fail_w[3]), .finish(finish_w[3]),
    .err_idx(err_w[3]), .dut(if3));

  // Bench DUTs. A "2-stage" DUT is one register behind the checker's
  // operand register; the "1-stage" DUT is combinational.
  always @(posedge clock) begin
    if0.dut_y <= (if0.dut_a + if0.dut_b) ^
                 {7'd0, (inj && if0.dut_a == 8'd15 && if0.dut_b == 8'd36)};
    if1.dut_y <= if1.dut_a + if1.dut_b;
    for (int l = 0; l < 4; l++)
      if2.dut_y[8*l +: 8] <= if2.dut_a[8*l +: 8] - if2.dut_b[8*l +: 8];
  end
  assign if3.dut_y = if3.dut_a + if3.dut_b;

  assign a_w[0] = {24'd0, if0.dut_a};  assign b_w[0] = {24'd0, if0.dut_b};  assign y_w[0] = {24'd0, if0.dut_y};
  assign a_w[1] = {24'd0, if1.dut_a};  assign b_w[1] = {24'd0, if1.dut_b};  assign y_w[1] = {24'd0, if1.dut_y};
  assign a_w[2] = if2.dut_a;           assign b_w[2] = if2.dut_b;           assign y_w[2] = if2.dut_y;
  assign a_w[3] = {24'd0, if3.dut_a};  assign b_w[3] = {24'd0, if3.dut_b};  assign y_w[3] = {24'd0, if3.dut_y};

  // cnt = number of reset-low edges since reset was last sampled high;
  // after edge E1+t, cnt = t+1. The fault flag is latched with reset.
  always @(posedge clock) begin
    for (int k = 0; k < NI; k++) cnt[k] <= rst[k] ? 0 : cnt[k] + 1;
    if (rst[0]) inj_m <= inj;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] vec_a(int lanes, int i);
    logic [31:0] r = '0;
    for (int k = 0; k < lanes; k++) r[8*k +: 8] = 8'(3*i + k);
    return r;
  endfunction

  function automatic logic [31:0] vec_b(int lanes, int i);
    logic [31:0] r = '0;
    for (int k = 0; k < lanes; k++) r[8*k +: 8] = 8'(7*i + 2*k + 1);
    return r;
  endfunction

  function automatic logic [31:0] gold(int lanes, int op, int i);
    logic [31:0] r = '0;
    for (int k = 0; k < lanes; k++)
      r[8*k +: 8] = (op == 0) ? 8'(3*i + k + 7*i + 2*k + 1)
                              : 8'((3*i + k) - (7*i + 2*k + 1));
    return r;
  endfunction

  // What the bench DUT of instance u presents when vector i is compared.
  function automatic logic [31:0] seen(int u, int i);
    logic [31:0] g = gold(LN[u], OPS[u], i);
    if (u == 0 && inj_m && i == 5) return g ^ 32'd1;
    if (u == 3) return (i + 1 < NV[u]) ? gold(LN[u], OPS[u], i + 1) : 32'd0;
    return g;
  endfunction

  function automatic int first_fail(int u);
    for (int i = 0; i < NV[u]; i++)
      if (seen(u, i) != gold(LN[u], OPS[u], i)) return i;
    return -1;
  endfunction

  task automatic chk(string nm, int u, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s u%0d cnt=%0d ph=%0d: got %0h, want %0h", nm, u, cnt[u], ph, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (run_chk) begin
      for (int u = 0; u < NI; u++) begin
        int t, fi;
        logic ef, efin, iss;
        logic [31:0] ea, eb, eerr;
        t  = cnt[u] - 1;
        fi = first_fail(u);
        if (cnt[u] == 0) begin
          ef = 0; efin = 0; eerr = 0; ea = 0; eb = 0;
        end else begin
          ef   = (fi >= 0) && (t >= fi + LAT[u]);
          efin = ef || ((fi < 0) && (t >= NV[u] - 1 + LAT[u]));
          eerr = ef ? 32'(fi) : 32'd0;
          iss  = (t < NV[u]) && !((fi >= 0) && (t >= fi + LAT[u] + 1));
          ea   = iss ? vec_a(LN[u], t) : 32'd0;
          eb   = iss ? vec_b(LN[u], t) : 32'd0;
        end
        chk("fail",    u, {31'd0, fail_w[u]},   {31'd0, ef});
        chk("finish",  u, {31'd0, finish_w[u]}, {31'd0, efin});
        chk("err_idx", u, {16'd0, err_w[u]},    eerr);
        chk("dut_a",   u, a_w[u], ea);
        chk("dut_b",   u, b_w[u], eb);
      end

      // Hand-computed anchors.
      if (ph == 0) begin
        if (cnt[0] == 6)  begin chk("u0 a5", 0, a_w[0], 32'd15); chk("u0 b5", 0, b_w[0], 32'd36); end
        if (cnt[0] == 7)  chk("u0 y5", 0, y_w[0], 32'd51);
        if (cnt[0] == 17) chk("u0 fin-early", 0, {31'd0, finish_w[0]}, 32'd0);
        if (cnt[0] == 18) begin
          chk("u0 fin", 0, {31'd0, finish_w[0]}, 32'd1);
          chk("u0 pass", 0, {31'd0, fail_w[0]}, 32'd0);
        end
        if (cnt[1] == 37) begin chk("u1 a36", 1, a_w[1], 32'd108); chk("u1 b36", 1, b_w[1], 32'd253); end
        if (cnt[1] == 38) chk("u1 y36", 1, y_w[1], 32'd105);
        if (cnt[1] == 41) chk("u1 fin-early", 1, {31'd0, finish_w[1]}, 32'd0);
        if (cnt[1] == 42) begin
          chk("u1 fin", 1, {31'd0, finish_w[1]}, 32'd1);
          chk("u1 pass", 1, {31'd0, fail_w[1]}, 32'd0);
        end
        if (cnt[2] == 3) begin
          chk("u2 a2l3", 2, {24'd0, a_w[2][31:24]}, 32'd9);
          chk("u2 b2l3", 2, {24'd0, b_w[2][31:24]}, 32'd21);
        end
        if (cnt[2] == 4)  chk("u2 y2l3", 2, {24'd0, y_w[2][31:24]}, 32'd244);
        if (cnt[2] == 40) chk("u2 pass", 2, {31'd0, fail_w[2]}, 32'd0);
        if (cnt[3] == 2) begin
          chk("u3 y", 3, y_w[3], 32'd11);
          chk("u3 pre", 3, {31'd0, fail_w[3]}, 32'd0);
        end
        if (cnt[3] == 3) begin
          chk("u3 fail", 3, {31'd0, fail_w[3]}, 32'd1);
          chk("u3 err", 3, {16'd0, err_w[3]}, 32'd0);
        end
      end
      if (ph == 1) begin
        if (cnt[0] == 7) chk("u0 flt-pre", 0, {31'd0, fail_w[0]}, 32'd0);
        if (cnt[0] == 8) begin
          chk("u0 flt", 0, {31'd0, fail_w[0]}, 32'd1);
          chk("u0 flt-fin", 0, {31'd0, finish_w[0]}, 32'd1);
          chk("u0 flt-err", 0, {16'd0, err_w[0]}, 32'd5);
        end
        if (cnt[0] == 28) begin
          chk("u0 flt-hold", 0, {16'd0, err_w[0]}, 32'd5);
          chk("u0 flt-a0", 0, a_w[0], 32'd0);
        end
      end
      if (ph == 2) begin
        if (rst[0] && cnt[0] == 0) chk("u0 rst-fin", 0, {31'd0, finish_w[0]}, 32'd0);
        if (cnt[0] == 18) begin
          chk("u0 rerun-fin", 0, {31'd0, finish_w[0]}, 32'd1);
          chk("u0 rerun-pass", 0, {31'd0, fail_w[0]}, 32'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = '1; inj = 1'b0; ph = 0; run_chk = 1'b0;
    repeat (3) @(posedge clock);
    #1 run_chk = 1'b1; rst = '0;
    repeat (60) @(posedge clock);

    #1 ph = 1; inj = 1'b1; rst[0] = 1'b1;
    repeat (2) @(posedge clock);
    #1 rst[0] = 1'b0;
    repeat (40) @(posedge clock);

    #1 ph = 2; inj = 1'b0; rst[0] = 1'b1;
    repeat (2) @(posedge clock);
    #1 rst[0] = 1'b0;
    repeat (6) @(posedge clock);
    #1 rst[0] = 1'b1;
    repeat (2) @(posedge clock);
    #1 rst[0] = 1'b0;
    repeat (40) @(posedge clock);

    #1 run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
